// File: rtl/mixcol_addkey_seq_if.sv
// Handshake and data bundle for the MixColumns/AddRoundKey round-tail stage.
// The slave modport is the stage's view of the bundle; the master modport is the driver's view.
interface mixcol_addkey_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   modport slave (
      input  in_valid, in_state, in_key, in_last, out_ready,
      output in_ready, out_valid, out_state, busy
   );

   modport master (
      output in_valid, in_state, in_key, in_last, out_ready,
      input  in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/mixcol_addkey_seq.sv
// AES round tail: column-serial MixColumns followed by AddRoundKey, with valid/ready on both sides.
// COLS_PER_CYCLE columns are finished per clock; the last-round flag skips the mixing.
module mixcol_addkey_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   mixcol_addkey_seq_if.slave bus
);
   localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
         $error("COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

   state_t       r_state, w_state_nxt;
   logic [127:0] r_st, r_key, r_res;
   logic         r_last;
   logic [1:0]   r_idx;
   logic         w_acc;

   logic [COLS_PER_CYCLE-1:0][31:0] w_col;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix(input logic [31:0] c);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = c;
      return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
              xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
   endfunction

   // One datapath slot per column handled in a cycle; slot g serves column r_idx+g.
   generate
      for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
         logic [1:0]  w_c;
         logic [31:0] w_st_col, w_key_col;
         assign w_c       = r_idx + 2'(g);
         assign w_st_col  = r_st[127 - 32*int'(w_c) -: 32];
         assign w_key_col = r_key[127 - 32*int'(w_c) -: 32];
         assign w_col[g]  = (r_last ? w_st_col : mix(w_st_col)) ^ w_key_col;
      end
   endgenerate

   assign bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
   assign w_acc         = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state == S_PROC) || (r_state == S_DONE);
   assign bus.out_state = r_res;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_acc) w_state_nxt = S_PROC;
         S_PROC: if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
         S_DONE: if (bus.out_ready) w_state_nxt = w_acc ? S_PROC : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result register changes only in PROC, so a held DONE output is never disturbed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st   <= '0;
         r_key  <= '0;
         r_last <= 1'b0;
         r_idx  <= '0;
         r_res  <= '0;
      end else begin
         if (w_acc) begin
            r_st   <= bus.in_state;
            r_key  <= bus.in_key;
            r_last <= bus.in_last;
            r_idx  <= '0;
         end
         if (r_state == S_PROC) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
               r_res[127 - 32*int'(r_idx + 2'(g)) -: 32] <= w_col[g];
            end
            r_idx <= r_idx + IDX_STEP;
         end
      end
   end
endmodule

// File: tb/tb_mixcol_addkey_seq.sv
// Directed bench for mixcol_addkey_seq: three widths (1, 2, 4 columns/cycle) share one stimulus.
// Expected results are hand-computed AES MixColumns/AddRoundKey vectors.
module tb_mixcol_addkey_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   logic         in_valid = 1'b0;
   logic [127:0] in_state = '0;
   logic [127:0] in_key   = '0;
   logic         in_last  = 1'b0;
   logic         out_ready = 1'b0;

   int checks   = 0;
   int failures = 0;

   mixcol_addkey_seq_if if1 ();
   mixcol_addkey_seq_if if2 ();
   mixcol_addkey_seq_if if4 ();

   assign if1.in_valid = in_valid;  assign if1.in_state = in_state;  assign if1.in_key = in_key;
   assign if1.in_last  = in_last;   assign if1.out_ready = out_ready;
   assign if2.in_valid = in_valid;  assign if2.in_state = in_state;  assign if2.in_key = in_key;
   assign if2.in_last  = in_last;   assign if2.out_ready = out_ready;
   assign if4.in_valid = in_valid;  assign if4.in_state = in_state;  assign if4.in_key = in_key;
   assign if4.in_last  = in_last;   assign if4.out_ready = out_ready;

   mixcol_addkey_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   mixcol_addkey_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
   mixcol_addkey_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

   always #5 clk = ~clk;

   localparam logic [127:0] ST1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] EXP1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] KEY2 = {16{8'h01}};
   localparam logic [127:0] EXP2 = 128'h8f4ca0bd_9edd599c_00000000_c7c7c7c7;
   localparam logic [127:0] ST3  = 128'hd4d4d4d5_2d26314c_00000000_00000000;
   localparam logic [127:0] EXP3 = 128'h2b2b2b2a_d2d9ceb3_ffffffff_ffffffff;
   localparam logic [127:0] ST4  = 128'h2d26314c_00000000_00000000_00000000;
   localparam logic [127:0] EXP4 = 128'h4d7ebdf8_00000000_00000000_00000000;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one block and let the accept edge take it.
   task automatic start(input logic [127:0] st, input logic [127:0] key, input logic last);
      in_state = st;
      in_key   = key;
      in_last  = last;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_state = '0;
      in_key   = '0;
      in_last  = 1'b0;
   endtask

   // Count edges from the accept edge until each instance raises out_valid, then check the data.
   task automatic wait_res(input string tag, input logic [127:0] exp);
      int n1, n2, n4;
      n1 = -1; n2 = -1; n4 = -1;
      for (int e = 1; e <= 12 && n1 < 0; e++) begin
         if (if2.out_valid && n2 < 0) n2 = e - 1;
         if (if4.out_valid && n4 < 0) n4 = e - 1;
         tick();
         if (if1.out_valid && n1 < 0) n1 = e;
         if (if2.out_valid && n2 < 0) n2 = e;
         if (if4.out_valid && n4 < 0) n4 = e;
      end
      chk({tag, "_lat1"}, 128'(n1), 128'd4);
      chk({tag, "_lat2"}, 128'(n2), 128'd2);
      chk({tag, "_lat4"}, 128'(n4), 128'd1);
      chk({tag, "_out1"}, if1.out_state, exp);
      chk({tag, "_out2"}, if2.out_state, exp);
      chk({tag, "_out4"}, if4.out_state, exp);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_vld_drop"}, 128'(if1.out_valid), 128'd0);
      chk({tag, "_busy_drop"}, 128'(if1.busy), 128'd0);
   endtask

   initial begin
      logic [127:0] held;
      logic seen;

      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 128'(if1.out_valid), 128'd0);
      chk("rst_out_state", if1.out_state, 128'd0);
      chk("rst_busy", 128'(if1.busy), 128'd0);
      chk("rst_in_ready", 128'(if1.in_ready), 128'd1);

      // 1: mix only
      start(ST1, '0, 1'b0);
      chk("t1_busy", 128'(if1.busy), 128'd1);
      chk("t1_in_ready_proc", 128'(if1.in_ready), 128'd0);
      wait_res("t1", EXP1);
      drain("t1");

      // 2: mix plus key
      start(ST1, KEY2, 1'b0);
      wait_res("t2", EXP2);
      drain("t2");

      // 3: last round bypasses mixing
      start(ST3, {16{8'hff}}, 1'b1);
      wait_res("t3", EXP3);
      drain("t3");

      // 4: backpressure, then back-to-back accept on the release edge
      start(ST1, '0, 1'b0);
      wait_res("t4a", EXP1);
      in_state = ST4;
      in_key   = '0;
      in_last  = 1'b0;
      in_valid = 1'b1;
      held = if1.out_state;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_vld", 128'(if1.out_valid), 128'd1);
         chk("t4_hold_state", if1.out_state, held);
         chk("t4_hold_in_ready", 128'(if1.in_ready), 128'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("t4_in_ready_rel", 128'(if1.in_ready), 128'd1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;
      chk("t4_b2b_vld", 128'(if1.out_valid), 128'd0);
      chk("t4_b2b_busy", 128'(if1.busy), 128'd1);
      wait_res("t4b", EXP4);
      drain("t4b");

      // 5: reset two edges after accept aborts the block
      start(ST1, '0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", 128'(if1.busy), 128'd0);
      chk("t5_in_ready", 128'(if1.in_ready), 128'd1);
      chk("t5_out_state", if1.out_state, 128'd0);
      chk("t5_busy4", 128'(if4.busy), 128'd0);
      chk("t5_out_state4", if4.out_state, 128'd0);
      seen = if1.out_valid;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | if1.out_valid;
      end
      chk("t5_no_vld", 128'(seen), 128'd0);
      start(ST1, '0, 1'b0);
      wait_res("t5r", EXP1);
      drain("t5r");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mixcol_addkey_seq.md
Name: mixcol_addkey_seq

Overview:
- Sequential round-tail stage for the AES datapath. It takes a full 128-bit state that has already been through ShiftRows, plus the 128-bit round key.
- It runs the state column-by-column through an internal 32-bit MixColumns datapath, then XORs in the round key (AddRoundKey). The result is handed downstream as the next round state.
- Operation is a valid/ready handshake on both sides. A last-round flag bypasses MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock. Legal values are 1, 2 or 4; any other value is a synthesis error. Define NCYC = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents state/key/last.
- in_ready  output  1  block can accept a transfer.
- in_state  input  128  ShiftRows output. Column 0 = [127:96], byte order within a column MSB-first (row 0 at the top).
- in_key  input  128  round key, same column layout.
- in_last  input  1  final round: skip MixColumns, AddRoundKey only.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_state  output  128  round result.
- busy  output  1  high in PROC or DONE.

Behaviour:
- Reset is synchronous; rst wins over every other input on the same edge. After reset:
  - FSM = IDLE, out_valid = 0, out_state = 0, busy = 0, column index = 0, captured registers = 0.
  - in_ready = 1 in the first cycle after reset.
- FSM states are IDLE, PROC and DONE.
- in_ready is combinational: in_ready = (IDLE) or (DONE and out_ready).
- Accept happens on any edge where in_valid & in_ready. On accept:
  - in_state, in_key and in_last are captured into internal registers.
  - Column index is set to 0 and the FSM goes to PROC.
  - Inputs are don't-care after the accept edge.
- PROC, each edge:
  - Columns idx .. idx+COLS_PER_CYCLE-1 are computed from the captured state.
  - Per byte column (b0..b3), last = 0:
    - r0 = 2·b0 ^ 3·b1 ^ b2 ^ b3
    - r1 = b0 ^ 2·b1 ^ 3·b2 ^ b3
    - r2 = b0 ^ b1 ^ 2·b2 ^ 3·b3
    - r3 = 3·b0 ^ b1 ^ b2 ^ 2·b3
  - GF(2^8) arithmetic: 2·x = (x<<1) ^ (x[7] ? 0x1B : 0x00), truncated to 8 bits; 3·x = 2·x ^ x.
  - When last = 1, r = b (no mixing).
  - Each result column is XORed with the matching key column and written into the result register slot.
  - idx advances by COLS_PER_CYCLE. On the edge that writes the final group (idx = 4-COLS_PER_CYCLE), the FSM goes to DONE.
- Latency: out_valid rises after exactly NCYC rising edges following the accept edge. It is 4 for the default and 1 for COLS_PER_CYCLE = 4.
- DONE:
  - out_valid = 1; out_state = result register, held stable while out_ready = 0.
  - Unaccepted output is never dropped or altered.
- Leaving DONE on an edge with out_ready = 1:
  - With in_valid = 1, the new input is accepted on that same edge and the FSM goes straight to PROC (no bubble). Throughput is one block per NCYC+1 cycles.
  - With in_valid = 0, the FSM goes to IDLE and out_valid = 0 on the next cycle. out_state keeps its last value; it is only meaningful while out_valid = 1.
- The result register is written only in PROC. Partial results of a new block are never visible while out_valid = 1.
- Reset in PROC or DONE aborts the operation. No out_valid pulse follows, and the FSM is IDLE the next cycle.
- While IDLE with in_valid = 0, all outputs hold.

Test Plan:
1. Mix only. Stimulus: in_state = db135345_f20a225c_01010101_c6c6c6c6, in_key = 0, in_last = 0. Required: out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid high 4 edges after accept (default parameter).
2. Mix plus key. Stimulus: same state, in_key = 0x01 repeated in all 16 bytes. Required: out_state = 8f4ca0bd_9edd599c_00000000_c7c7c7c7.
3. Last round. Stimulus: in_last = 1, in_state = d4d4d4d5_2d26314c_00000000_00000000, in_key = all ff. Required: out_state = 2b2b2b2a_d2d9ceb3_ffffffff_ffffffff.
4. Backpressure and back-to-back.
   - Hold out_ready = 0 for 5 cycles in DONE. Required: out_valid = 1, out_state constant, in_ready = 0 throughout.
   - Then raise out_ready with in_valid = 1 (in_state = 2d26314c_0...0, key 0). Required: accepted on the same edge; next result column 0 = 4d7ebdf8 after 4 edges.
5. Reset mid-operation. Stimulus: assert rst for 1 cycle, 2 edges after accept. Required: out_valid never rises, busy = 0 and in_ready = 1 the cycle after rst, out_state = 0. A following test-1 transfer gives the correct result.
6. Parameter variant. Stimulus: COLS_PER_CYCLE = 4 and 2, running test 1. Required: identical out_state, out_valid after 1 and 2 edges respectively.
